// File: rtl/mem_access_sequencer_pkg.sv
// Shared constants for the decode -> memory-access path.
// Writeback source codes, load/store width codes and sequencer states.
package mem_access_sequencer_pkg;

  localparam logic [1:0] REG_WRITE_SRC_NONE = 2'd0;
  localparam logic [1:0] REG_WRITE_SRC_ALU  = 2'd1;
  localparam logic [1:0] REG_WRITE_SRC_MEM  = 2'd2;
  localparam logic [1:0] REG_WRITE_SRC_RSVD = 2'd3;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic f3_legal(
    input logic       is_store,
    input logic [2:0] f3
  );
    if (is_store)
      return f3 == F3_SB || f3 == F3_SH || f3 == F3_SW;
    return f3 == F3_LB || f3 == F3_LH || f3 == F3_LW ||
           f3 == F3_LBU || f3 == F3_LHU;
  endfunction

endpackage

// File: rtl/mem_access_sequencer_load_data_extractor.sv
// Picks the addressed lane of a load word and sign/zero-extends it.
// Pure combinational; shared with future cache read paths.
module load_data_extractor
  import mem_access_sequencer_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[{addr, 3'b000} +: 8];
    half_v = rdata[{addr[1], 4'b0000} +: 16];
    unique case (funct3)
      F3_LB:   value = {{24{byte_v[7]}}, byte_v};
      F3_LH:   value = {{16{half_v[15]}}, half_v};
      F3_LBU:  value = {24'd0, byte_v};
      F3_LHU:  value = {16'd0, half_v};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Issues one data-memory transaction per accepted control word and
// produces register writeback for ALU results and loads.
module mem_access_sequencer
  import mem_access_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic              should_read_mem,
  input  logic              should_write_mem,
  input  logic              should_write_reg,
  input  logic [1:0]        reg_write_src,
  input  logic [4:0]        rd_addr,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [3:0]        mem_req_wstrb,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  output logic              wb_en,
  output logic [4:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              fault
);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] sd_q;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic              wr_q, wbf_q;

  logic              wb_en_d, fault_d;
  logic [4:0]        wb_addr_d;
  logic [DATA_W-1:0] wb_data_d;

  logic accept, is_mem, misal, bad, start;
  logic [31:0] load_val;

  assign issue_ready = (state_q == IDLE);
  assign accept = issue_valid & issue_ready;
  assign is_mem = should_read_mem | should_write_mem;

  always_comb begin
    misal = (funct3[1:0] == 2'b01 && alu_result[0]) ||
            (funct3[1:0] == 2'b10 && alu_result[1:0] != 2'b00);
    bad = (should_read_mem & should_write_mem) ||
          !f3_legal(should_write_mem, funct3) || misal;
  end

  assign start = accept & is_mem & ~bad;

  load_data_extractor u_ext (
    .rdata  (mem_resp_rdata),
    .addr   (addr_q[1:0]),
    .funct3 (f3_q),
    .value  (load_val)
  );

  always_comb begin
    state_d   = state_q;
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr;
    wb_data_d = wb_data;
    fault_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && is_mem) begin
          if (bad) fault_d = 1'b1;
          else     state_d = REQ;
        end else if (accept && should_write_reg &&
                     reg_write_src == REG_WRITE_SRC_ALU &&
                     rd_addr != 5'd0) begin
          wb_en_d   = 1'b1;
          wb_addr_d = rd_addr;
          wb_data_d = DATA_W'(alu_result);
        end
      end
      REQ: begin
        if (mem_req_ready) state_d = RESP;
      end
      RESP: begin
        if (mem_resp_valid) begin
          state_d = IDLE;
          if (!wr_q && wbf_q) begin
            wb_en_d   = 1'b1;
            wb_addr_d = rd_q;
            wb_data_d = load_val;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wb_en   <= 1'b0;
      wb_addr <= 5'd0;
      wb_data <= '0;
      fault   <= 1'b0;
    end else begin
      state_q <= state_d;
      wb_en   <= wb_en_d;
      wb_addr <= wb_addr_d;
      wb_data <= wb_data_d;
      fault   <= fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      sd_q   <= '0;
      f3_q   <= 3'd0;
      rd_q   <= 5'd0;
      wr_q   <= 1'b0;
      wbf_q  <= 1'b0;
    end else if (start) begin
      addr_q <= alu_result;
      sd_q   <= store_data;
      f3_q   <= funct3;
      rd_q   <= rd_addr;
      wr_q   <= should_write_mem;
      wbf_q  <= should_write_reg &&
                reg_write_src == REG_WRITE_SRC_MEM &&
                rd_addr != 5'd0;
    end
  end

  // Request fields come only from latched state, so they hold until ready.
  assign mem_req_valid = (state_q == REQ);
  assign mem_req_write = wr_q;
  assign mem_req_addr  = {addr_q[ADDR_W-1:2], 2'b00};

  always_comb begin
    unique case (f3_q[1:0])
      2'b00:   mem_req_wdata = {4{sd_q[7:0]}};
      2'b01:   mem_req_wdata = {2{sd_q[15:0]}};
      default: mem_req_wdata = sd_q;
    endcase
    if (!wr_q)
      mem_req_wstrb = 4'b0000;
    else if (f3_q[1:0] == 2'b00)
      mem_req_wstrb = 4'b0001 << addr_q[1:0];
    else if (f3_q[1:0] == 2'b01)
      mem_req_wstrb = 4'b0011 << addr_q[1:0];
    else
      mem_req_wstrb = 4'b1111;
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed-vector bench for mem_access_sequencer.
// Inputs change and outputs are sampled on the falling edge.
module tb_mem_access_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_ready;
  logic        should_read_mem, should_write_mem, should_write_reg;
  logic [1:0]  reg_write_src;
  logic [4:0]  rd_addr;
  logic [2:0]  funct3;
  logic [31:0] alu_result, store_data;
  logic        mem_req_valid, mem_req_ready, mem_req_write;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        fault;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .issue_valid      (issue_valid),
    .issue_ready      (issue_ready),
    .should_read_mem  (should_read_mem),
    .should_write_mem (should_write_mem),
    .should_write_reg (should_write_reg),
    .reg_write_src    (reg_write_src),
    .rd_addr          (rd_addr),
    .funct3           (funct3),
    .alu_result       (alu_result),
    .store_data       (store_data),
    .mem_req_valid    (mem_req_valid),
    .mem_req_ready    (mem_req_ready),
    .mem_req_write    (mem_req_write),
    .mem_req_addr     (mem_req_addr),
    .mem_req_wdata    (mem_req_wdata),
    .mem_req_wstrb    (mem_req_wstrb),
    .mem_resp_valid   (mem_resp_valid),
    .mem_resp_rdata   (mem_resp_rdata),
    .wb_en            (wb_en),
    .wb_addr          (wb_addr),
    .wb_data          (wb_data),
    .fault            (fault)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one control word for a single accepting edge.
  task automatic issue(input logic rd, input logic wr,
                       input logic swr, input logic [1:0] src,
                       input logic [4:0] rda, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] sd);
    issue_valid      = 1'b1;
    should_read_mem  = rd;
    should_write_mem = wr;
    should_write_reg = swr;
    reg_write_src    = src;
    rd_addr          = rda;
    funct3           = f3;
    alu_result       = alu;
    store_data       = sd;
    step();
    issue_valid      = 1'b0;
    should_read_mem  = 1'b0;
    should_write_mem = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] rdata,
                          input logic [31:0] exp);
    mem_req_ready = 1'b1;
    issue(1'b1, 1'b0, 1'b1, 2'd2, 5'd7, f3, a, 32'h0);
    chk({tag, ".req_vld"}, 32'(mem_req_valid), 32'd1);
    chk({tag, ".req_addr"}, mem_req_addr, {a[31:2], 2'b00});
    chk({tag, ".wstrb"}, 32'(mem_req_wstrb), 32'd0);
    chk({tag, ".write"}, 32'(mem_req_write), 32'd0);
    chk({tag, ".rdy_req"}, 32'(issue_ready), 32'd0);
    step();
    chk({tag, ".vld_drop"}, 32'(mem_req_valid), 32'd0);
    chk({tag, ".rdy_resp"}, 32'(issue_ready), 32'd0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = rdata;
    step();
    mem_resp_valid = 1'b0;
    chk({tag, ".wb_en"}, 32'(wb_en), 32'd1);
    chk({tag, ".wb_addr"}, 32'(wb_addr), 32'd7);
    chk({tag, ".wb_data"}, wb_data, exp);
    chk({tag, ".rdy_done"}, 32'(issue_ready), 32'd1);
    step();
    chk({tag, ".wb_pulse"}, 32'(wb_en), 32'd0);
  endtask

  task automatic run_fault(input string tag, input logic rd,
                           input logic wr, input logic [2:0] f3,
                           input logic [31:0] a);
    mem_req_ready = 1'b1;
    issue(rd, wr, 1'b1, 2'd2, 5'd9, f3, a, 32'h5555_AAAA);
    chk({tag, ".fault"}, 32'(fault), 32'd1);
    chk({tag, ".no_req"}, 32'(mem_req_valid), 32'd0);
    chk({tag, ".no_wb"}, 32'(wb_en), 32'd0);
    chk({tag, ".ready"}, 32'(issue_ready), 32'd1);
    step();
    chk({tag, ".pulse"}, 32'(fault), 32'd0);
    chk({tag, ".no_req2"}, 32'(mem_req_valid), 32'd0);
  endtask

  initial begin
    reset            = 1'b1;
    issue_valid      = 1'b0;
    should_read_mem  = 1'b0;
    should_write_mem = 1'b0;
    should_write_reg = 1'b0;
    reg_write_src    = 2'd0;
    rd_addr          = 5'd0;
    funct3           = 3'd0;
    alu_result       = 32'h0;
    store_data       = 32'h0;
    mem_req_ready    = 1'b0;
    mem_resp_valid   = 1'b0;
    mem_resp_rdata   = 32'h0;
    step();
    step();
    chk("rst.ready", 32'(issue_ready), 32'd1);
    chk("rst.req_vld", 32'(mem_req_valid), 32'd0);
    chk("rst.wb_en", 32'(wb_en), 32'd0);
    chk("rst.wb_data", wb_data, 32'd0);
    chk("rst.fault", 32'(fault), 32'd0);
    reset = 1'b0;
    step();

    // ALU writeback, then rd=0 suppression
    issue(1'b0, 1'b0, 1'b1, 2'd1, 5'd5, 3'd0, 32'h1234, 32'h0);
    chk("addi.wb_en", 32'(wb_en), 32'd1);
    chk("addi.wb_addr", 32'(wb_addr), 32'd5);
    chk("addi.wb_data", wb_data, 32'h1234);
    chk("addi.ready", 32'(issue_ready), 32'd1);
    step();
    chk("addi.pulse", 32'(wb_en), 32'd0);
    issue(1'b0, 1'b0, 1'b1, 2'd1, 5'd0, 3'd0, 32'h9999, 32'h0);
    chk("addi_x0.wb_en", 32'(wb_en), 32'd0);

    run_load("lb", 3'd0, 32'h103, 32'h80FF_0000, 32'hFFFF_FF80);
    run_load("lbu", 3'd4, 32'h103, 32'h80FF_0000, 32'h0000_0080);
    run_load("lh", 3'd1, 32'h102, 32'hBEEF_0000, 32'hFFFF_BEEF);
    run_load("lhu", 3'd5, 32'h102, 32'hBEEF_0000, 32'h0000_BEEF);
    run_load("lw", 3'd2, 32'h44, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // SH with a stalled bus for three cycles
    mem_req_ready = 1'b0;
    issue(1'b0, 1'b1, 1'b0, 2'd0, 5'd3, 3'd1, 32'h202, 32'hABCD_1234);
    for (int i = 0; i < 3; i++) begin
      chk("sh.vld", 32'(mem_req_valid), 32'd1);
      chk("sh.addr", mem_req_addr, 32'h200);
      chk("sh.wdata", mem_req_wdata, 32'h1234_1234);
      chk("sh.wstrb", 32'(mem_req_wstrb), 32'hC);
      chk("sh.write", 32'(mem_req_write), 32'd1);
      chk("sh.ready", 32'(issue_ready), 32'd0);
      step();
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("sh.vld_drop", 32'(mem_req_valid), 32'd0);
    chk("sh.rdy_resp", 32'(issue_ready), 32'd0);
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    chk("sh.done_rdy", 32'(issue_ready), 32'd1);
    chk("sh.no_wb", 32'(wb_en), 32'd0);

    // SB lane placement
    mem_req_ready = 1'b1;
    issue(1'b0, 1'b1, 1'b0, 2'd0, 5'd3, 3'd0, 32'h301, 32'h0000_00A5);
    chk("sb.wdata", mem_req_wdata, 32'hA5A5_A5A5);
    chk("sb.wstrb", 32'(mem_req_wstrb), 32'h2);
    step();
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    chk("sb.done_rdy", 32'(issue_ready), 32'd1);

    run_fault("lw_mis", 1'b1, 1'b0, 3'd2, 32'h101);
    run_fault("lh_mis", 1'b1, 1'b0, 3'd1, 32'h103);
    run_fault("ld_f3", 1'b1, 1'b0, 3'd3, 32'h100);
    run_fault("st_f3", 1'b0, 1'b1, 3'd4, 32'h100);
    run_fault("rw_both", 1'b1, 1'b1, 3'd2, 32'h100);

    // Reset while waiting for the response, then a stale response
    mem_req_ready = 1'b1;
    issue(1'b1, 1'b0, 1'b1, 2'd2, 5'd8, 3'd2, 32'h40, 32'h0);
    step();
    chk("rstm.in_resp", 32'(issue_ready), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstm.ready", 32'(issue_ready), 32'd1);
    chk("rstm.vld", 32'(mem_req_valid), 32'd0);
    chk("rstm.wb_en", 32'(wb_en), 32'd0);
    chk("rstm.fault", 32'(fault), 32'd0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h1111_2222;
    step();
    mem_resp_valid = 1'b0;
    chk("stale.wb_en", 32'(wb_en), 32'd0);
    chk("stale.ready", 32'(issue_ready), 32'd1);
    chk("stale.vld", 32'(mem_req_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Consumes the per-instruction control word from the instruction control decoder: should_read_mem, should_write_mem, should_write_reg, reg_write_src, rd_addr.
- Carries out the requested data-memory transaction over a valid/ready bus.
- Produces the register writeback for both ALU results and loads.
- Sits between decode/execute and the data memory, and backpressures issue while a transaction is in flight.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, bus/register data width (fixed at 32; other values unsupported)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
issue_valid  in  1  control word and operands valid this cycle
issue_ready  out  1  sequencer can accept (state IDLE)
should_read_mem  in  1  load request
should_write_mem  in  1  store request
should_write_reg  in  1  writeback requested
reg_write_src  in  2  0=don't write, 1=ALU, 2=MEM, 3=reserved
rd_addr  in  5  destination register
funct3  in  3  access width/sign (instr[14:12])
alu_result  in  ADDR_W  effective address, or ALU value for writeback
store_data  in  DATA_W  rs2 value
mem_req_valid  out  1  bus request valid
mem_req_ready  in  1  bus accepts request
mem_req_write  out  1  1=store, 0=load
mem_req_addr  out  ADDR_W  word-aligned address
mem_req_wdata  out  DATA_W  lane-replicated store data
mem_req_wstrb  out  4  byte enables (0 for loads)
mem_resp_valid  in  1  response/ack
mem_resp_rdata  in  DATA_W  load word
wb_en  out  1  one-cycle writeback strobe
wb_addr  out  5  writeback register
wb_data  out  DATA_W  writeback value
fault  out  1  one-cycle misaligned/illegal-access pulse

Behaviour:
- States: IDLE, REQ, RESP. issue_ready = (state==IDLE). All registered outputs reset to 0; state resets to IDLE.
- Accept = issue_valid & issue_ready. issue_valid is ignored when not ready; the caller holds it.
- Accept with no memory access:
  - should_write_reg & reg_write_src==ALU & rd_addr!=0 -> next cycle wb_en=1, wb_data=alu_result, wb_addr=rd_addr.
  - Stays IDLE.
- Accept with should_read_mem & should_write_mem both set -> fault pulse next cycle. No request, no writeback.
- Legal funct3:
  - Load: 0=LB, 1=LH, 2=LW, 4=LBU, 5=LHU.
  - Store: 0=SB, 1=SH, 2=SW.
  - Any other value -> fault pulse, no request.
- Misaligned access (halfword with addr[0]=1; word with addr[1:0]!=0) -> fault pulse next cycle, no request, remain IDLE.
- Legal memory access:
  - Latch addr, funct3, rd, write flag and wb flag (should_write_reg & reg_write_src==MEM & rd!=0).
  - Go to REQ with mem_req_valid=1 on the next cycle.
- REQ:
  - mem_req_addr = {addr[31:2],2'b00}.
  - Store wdata: SB = byte ×4, SH = halfword ×2, SW = word.
  - wstrb: SB = 4'b0001<<addr[1:0]; SH = 4'b0011<<addr[1:0]; SW = 4'b1111; loads 0.
  - All request fields stay stable until mem_req_ready.
  - On the handshake cycle: mem_req_valid drops next cycle and state becomes RESP.
- RESP: wait for mem_resp_valid. A store completes on the ack.
- Load completion:
  - Select the byte/halfword lane by addr[1:0].
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - Register wb_en/wb_data/wb_addr for one cycle if the wb flag is set.
  - State returns to IDLE on the same edge.
- mem_resp_valid in IDLE or REQ is ignored.
- Best-case load latency: accept T; req T+1 (ready=1); resp T+2; wb_en and issue_ready at T+3.
- Store and load use the same timing, without wb_en.
- Reset mid-transaction:
  - Return to IDLE on that edge; mem_req_valid, wb_en and fault become 0.
  - A later stale mem_resp_valid is ignored.
- wb_en and fault are never both asserted in the same cycle.

Decomposition:
- Shared package (shared with the decoder): REG_WRITE_SRC_* constants, funct3 load/store codes, state enum.
- One combinational sub-module, load_data_extractor (rdata, addr[1:0], funct3 -> extended 32-bit value), reused later by any cache path.

Test Plan:
- ADDI-style: reg_write_src=ALU, rd=5, alu_result=0x1234 -> next cycle wb_en=1, wb_addr=5, wb_data=0x1234; with rd=0 -> wb_en stays 0.
- LB at 0x103, rdata=0x80FF_0000, ready/resp immediate -> req_addr=0x100, wstrb=0, wb_data=0xFFFF_FF80 at T+3; LBU -> 0x0000_0080.
- SH at 0x202, store_data=0xABCD_1234 -> wdata=0x1234_1234, wstrb=4'b1100, req_write=1; mem_req_ready held low 3 cycles -> fields stable, issue_ready=0 until ack.
- LW at 0x101 -> fault pulses one cycle, mem_req_valid never rises, issue_ready stays 1.
- LW at 0x40; assert reset while in RESP; then resp_valid arrives -> no wb_en, state IDLE, outputs 0.
- funct3=3 load, and read+write both set -> fault pulse each, no request.
